// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD init sequencer: script ROM encoding,
// panel command constants, sequencer states and SPI shifter phases.
package lcd_pkg;

    // Script entry opcodes
    typedef enum logic [1:0] {
        OP_CMD   = 2'd0,
        OP_DATA  = 2'd1,
        OP_DELAY = 2'd2,
        OP_END   = 2'd3
    } script_op_t;

    // Panel commands and parameters used by the built-in init script
    localparam logic [7:0] CMD_SLPOUT    = 8'h11;
    localparam logic [7:0] CMD_COLMOD    = 8'h3A;
    localparam logic [7:0] CMD_DISPON    = 8'h29;
    localparam logic [7:0] COLMOD_RGB565 = 8'h55;

    localparam int SCRIPT_IDX_W = 3;

    typedef struct packed {
        script_op_t op;
        logic [7:0] data;
    } script_entry_t;

    // Sequencer states
    typedef enum logic [2:0] {
        RST_LO,
        RST_HI,
        FETCH,
        XFER,
        GAP,
        DELAY,
        USER_IDLE,
        USER_XFER
    } seq_state_t;

    // Phases of one SPI byte: SCK low, SCK high, trailing hold before CS rises
    typedef enum logic [1:0] {
        PH_LOW,
        PH_HIGH,
        PH_TAIL
    } spi_phase_t;

    // Built-in init script; indices past the last entry read as END
    function automatic script_entry_t script_rom(input logic [SCRIPT_IDX_W-1:0] idx);
        script_entry_t e;
        case (idx)
            3'd0:    e = '{op: OP_CMD,   data: CMD_SLPOUT};
            3'd1:    e = '{op: OP_DELAY, data: 8'h00};
            3'd2:    e = '{op: OP_CMD,   data: CMD_COLMOD};
            3'd3:    e = '{op: OP_DATA,  data: COLMOD_RGB565};
            3'd4:    e = '{op: OP_CMD,   data: CMD_DISPON};
            default: e = '{op: OP_END,   data: 8'h00};
        endcase
        return e;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_spi_byte_tx.sv
// SPI mode-0 byte shifter, MSB first. CS falls and bit 7 is presented on the
// edge that accepts start; each bit is SCK_DIV cycles low then SCK_DIV cycles
// high, followed by an SCK_DIV-cycle low hold before CS rises, giving a
// CS-low window of exactly 17*SCK_DIV cycles. done is high in the final
// cycle of that window so the owner can move on at the CS-rise edge.
module lcd_spi_byte_tx
    import lcd_pkg::*;
#(
    parameter int SCK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] tx_byte,
    output logic       busy,
    output logic       done,
    output logic       sck,
    output logic       sda,
    output logic       cs
);

    localparam int             DIV_W    = $clog2(SCK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

    spi_phase_t       phase;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [6:0]       shreg;

    // Phase/bit sequencing and pin registers for one byte
    always_ff @(posedge clk) begin
        // NOTE: every state element here is assigned with <= so all flops
        // update together from pre-edge values; blocking = would leak the
        // new value into later statements of the same edge.
        if (!rst_n) begin
            busy    <= 1'b0;
            phase   <= PH_LOW;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sck     <= 1'b0;
            sda     <= 1'b0;
            cs      <= 1'b1;
        end else if (!busy) begin
            if (start) begin
                busy    <= 1'b1;
                phase   <= PH_LOW;
                div_cnt <= '0;
                bit_cnt <= '0;
                shreg   <= tx_byte[6:0];
                sck     <= 1'b0;
                sda     <= tx_byte[7];
                cs      <= 1'b0;
            end
        end else if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
        end else begin
            div_cnt <= '0;
            case (phase)
                PH_LOW: begin
                    sck   <= 1'b1;
                    phase <= PH_HIGH;
                end
                PH_HIGH: begin
                    sck <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        phase <= PH_TAIL;
                    end else begin
                        // SDA only moves on the SCK falling edge
                        bit_cnt <= bit_cnt + 3'd1;
                        sda     <= shreg[6];
                        shreg   <= {shreg[5:0], 1'b0};
                        phase   <= PH_LOW;
                    end
                end
                PH_TAIL: begin
                    cs    <= 1'b1;
                    busy  <= 1'b0;
                    phase <= PH_LOW;
                end
                default: begin
                    cs    <= 1'b1;
                    busy  <= 1'b0;
                    phase <= PH_LOW;
                end
            endcase
        end
    end

    assign done = busy && (phase == PH_TAIL) && (div_cnt == DIV_LAST);

endmodule

// File: rtl/lcd_init_seq.sv
// LCD bring-up sequencer: hardware reset pulse, built-in init script over
// SPI, then a valid/ready byte port for upstream command/pixel logic.
module lcd_init_seq
    import lcd_pkg::*;
#(
    parameter int SCK_DIV        = 4,
    parameter int RST_LOW_CYC    = 1048576,
    parameter int RST_WAIT_CYC   = 1048576,
    parameter int SLEEP_WAIT_CYC = 4320000,
    parameter int GAP_CYC        = 4
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       TX_VALID,
    input  logic       TX_DC,
    input  logic [7:0] TX_DATA,
    output logic       TX_READY,
    output logic       INIT_DONE,
    output logic       LED,
    output logic       SCK,
    output logic       SDA,
    output logic       DC,
    output logic       CS,
    output logic       RST
);

    localparam int MAX_CYC = max_int(max_int(RST_LOW_CYC, RST_WAIT_CYC),
                                     max_int(SLEEP_WAIT_CYC, GAP_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // The FETCH cycle that follows RST_HI is part of the post-reset wait, so
    // RST_HI itself lasts one cycle less than RST_WAIT_CYC.
    localparam int RST_HI_CYC = (RST_WAIT_CYC >= 2) ? RST_WAIT_CYC - 1 : 1;

    localparam logic [CNT_W-1:0] RST_LO_LAST = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RST_HI_LAST = CNT_W'(RST_HI_CYC - 1);
    localparam logic [CNT_W-1:0] SLEEP_LAST  = CNT_W'(SLEEP_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);

    seq_state_t              state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [SCRIPT_IDX_W-1:0] idx, idx_nxt;
    logic                    rst_q, rst_nxt;
    logic                    dc_q, dc_nxt;
    logic                    led_q, led_nxt;
    logic                    init_done_q, init_done_nxt;

    script_entry_t entry;
    logic          spi_start;
    logic [7:0]    spi_byte;
    logic          spi_busy;
    logic          spi_done;

    assign entry = script_rom(idx);

    // Sequencer state and registered outputs
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state       <= RST_LO;
            cnt         <= '0;
            idx         <= '0;
            rst_q       <= 1'b0;
            dc_q        <= 1'b0;
            led_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            idx         <= idx_nxt;
            rst_q       <= rst_nxt;
            dc_q        <= dc_nxt;
            led_q       <= led_nxt;
            init_done_q <= init_done_nxt;
        end
    end

    // Next-state, counter and byte-launch decisions
    always_comb begin
        // NOTE: every signal written below gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        rst_nxt       = rst_q;
        dc_nxt        = dc_q;
        led_nxt       = led_q;
        init_done_nxt = init_done_q;
        spi_start     = 1'b0;
        spi_byte      = (state == USER_IDLE) ? TX_DATA : entry.data;

        case (state)
            RST_LO: begin
                if (cnt == RST_LO_LAST) begin
                    cnt_nxt   = '0;
                    rst_nxt   = 1'b1;
                    led_nxt   = 1'b1;
                    state_nxt = RST_HI;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            RST_HI: begin
                if (cnt == RST_HI_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    state_nxt = FETCH;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            FETCH: begin
                case (entry.op)
                    OP_CMD, OP_DATA: begin
                        dc_nxt    = (entry.op == OP_DATA);
                        led_nxt   = ~led_q;
                        spi_start = 1'b1;
                        state_nxt = XFER;
                    end
                    OP_DELAY: begin
                        cnt_nxt   = '0;
                        state_nxt = DELAY;
                    end
                    default: begin
                        init_done_nxt = 1'b1;
                        led_nxt       = 1'b1;
                        state_nxt     = USER_IDLE;
                    end
                endcase
            end

            XFER, USER_XFER: begin
                if (spi_done) begin
                    cnt_nxt   = '0;
                    state_nxt = GAP;
                end
            end

            // Shared inter-byte gap; after init it returns to the user port
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (init_done_q) begin
                        state_nxt = USER_IDLE;
                    end else begin
                        idx_nxt   = idx + SCRIPT_IDX_W'(1);
                        state_nxt = FETCH;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            DELAY: begin
                if (cnt == SLEEP_LAST) begin
                    cnt_nxt   = '0;
                    idx_nxt   = idx + SCRIPT_IDX_W'(1);
                    state_nxt = FETCH;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            USER_IDLE: begin
                if (TX_VALID && TX_READY) begin
                    dc_nxt    = TX_DC;
                    spi_start = 1'b1;
                    state_nxt = USER_XFER;
                end
            end

            default: begin
                cnt_nxt   = '0;
                state_nxt = RST_LO;
            end
        endcase
    end

    lcd_spi_byte_tx #(
        .SCK_DIV(SCK_DIV)
    ) u_spi (
        .clk    (CLK),
        .rst_n  (RSTN),
        .start  (spi_start),
        .tx_byte(spi_byte),
        .busy   (spi_busy),
        .done   (spi_done),
        .sck    (SCK),
        .sda    (SDA),
        .cs     (CS)
    );

    assign TX_READY  = (state == USER_IDLE) && !spi_busy;
    assign INIT_DONE = init_done_q;
    assign LED       = led_q;
    assign DC        = dc_q;
    assign RST       = rst_q;

endmodule

// File: tb/tb_lcd_init_seq.sv
// Bench for lcd_init_seq: two instances (SCK_DIV=2 and SCK_DIV=5) with short
// timing parameters; a negedge SPI monitor per bus compares captured
// (DC, byte) pairs and CS-low window shape against a queue of expectations.
module tb_lcd_init_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: SCK_DIV=2
    logic       rstn_a, tx_valid_a, tx_dc_a;
    logic [7:0] tx_data_a;
    logic       tx_ready_a, init_done_a, led_a, sck_a, sda_a, dc_a, cs_a, rst_a;
    // Instance B: SCK_DIV=5
    logic       rstn_b, tx_valid_b, tx_dc_b;
    logic [7:0] tx_data_b;
    logic       tx_ready_b, init_done_b, led_b, sck_b, sda_b, dc_b, cs_b, rst_b;

    lcd_init_seq #(
        .SCK_DIV(2), .RST_LOW_CYC(16), .RST_WAIT_CYC(8),
        .SLEEP_WAIT_CYC(40), .GAP_CYC(2)
    ) dut_a (
        .CLK(clk), .RSTN(rstn_a), .TX_VALID(tx_valid_a), .TX_DC(tx_dc_a),
        .TX_DATA(tx_data_a), .TX_READY(tx_ready_a), .INIT_DONE(init_done_a),
        .LED(led_a), .SCK(sck_a), .SDA(sda_a), .DC(dc_a), .CS(cs_a), .RST(rst_a)
    );

    lcd_init_seq #(
        .SCK_DIV(5), .RST_LOW_CYC(16), .RST_WAIT_CYC(8),
        .SLEEP_WAIT_CYC(40), .GAP_CYC(2)
    ) dut_b (
        .CLK(clk), .RSTN(rstn_b), .TX_VALID(tx_valid_b), .TX_DC(tx_dc_b),
        .TX_DATA(tx_data_b), .TX_READY(tx_ready_b), .INIT_DONE(init_done_b),
        .LED(led_b), .SCK(sck_b), .SDA(sda_b), .DC(dc_b), .CS(cs_b), .RST(rst_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Scoreboard queues of expected {dc, byte}
    logic [8:0] q_a[$];
    logic [8:0] q_b[$];

    task automatic push_script(input int k);
        logic [8:0] s [4];
        s[0] = {1'b0, 8'h11};
        s[1] = {1'b0, 8'h3A};
        s[2] = {1'b1, 8'h55};
        s[3] = {1'b0, 8'h29};
        for (int i = 0; i < 4; i++) begin
            if (k == 0) q_a.push_back(s[i]);
            else        q_b.push_back(s[i]);
        end
    endtask

    // Monitor state, one slot per bus
    logic       cs_p [2] = '{1'b1, 1'b1};
    logic       sck_p[2] = '{1'b0, 1'b0};
    int         low_len[2];
    int         rises[2];
    logic [7:0] shv[2];
    logic       dcv[2];
    int         nbytes[2] = '{0, 0};
    int         fall_at[2][32];
    int         rise_at[2][32];
    int         cur_fall[2];
    int         cyc = 0;

    task automatic mon(input int k, input logic cs, input logic sck, input logic sda,
                       input logic dc, input logic rstn, input int win);
        logic [31:0] e;
        if (!cs) begin
            if (cs_p[k]) begin
                low_len[k]  = 0;
                rises[k]    = 0;
                cur_fall[k] = cyc;
            end
            low_len[k] = low_len[k] + 1;
            if (sck && !sck_p[k]) begin
                rises[k] = rises[k] + 1;
                shv[k]   = {shv[k][6:0], sda};
                dcv[k]   = dc;
            end
        end else if (!cs_p[k] && rstn) begin
            // A window closed by reset is an intentional abort and is dropped
            e = 32'hFFFF_FFFF;
            if (k == 0 && q_a.size() > 0) e = {23'b0, q_a.pop_front()};
            if (k == 1 && q_b.size() > 0) e = {23'b0, q_b.pop_front()};
            check("bus dc/byte", {23'b0, dcv[k], shv[k]}, e);
            check("cs low window", low_len[k], win);
            check("sck rises per byte", rises[k], 8);
            if (nbytes[k] < 32) begin
                fall_at[k][nbytes[k]] = cur_fall[k];
                rise_at[k][nbytes[k]] = cyc;
            end
            nbytes[k] = nbytes[k] + 1;
        end
        cs_p[k]  = cs;
        sck_p[k] = sck;
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        mon(0, cs_a, sck_a, sda_a, dc_a, rstn_a, 34);
        mon(1, cs_b, sck_b, sda_b, dc_b, rstn_b, 85);
    end

    int edges = 0;
    always @(posedge clk) edges = edges + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   n, zeros, acc1, acc2, base, r;
    logic prev;

    initial begin
        rstn_a = 1'b0; tx_valid_a = 1'b0; tx_dc_a = 1'b0; tx_data_a = 8'h00;
        rstn_b = 1'b0; tx_valid_b = 1'b0; tx_dc_b = 1'b0; tx_data_b = 8'h00;
        repeat (4) @(posedge clk);
        #1;

        // Reset values
        check("reset CS", cs_a, 1);
        check("reset SCK", sck_a, 0);
        check("reset SDA", sda_a, 0);
        check("reset DC", dc_a, 0);
        check("reset RST", rst_a, 0);
        check("reset LED", led_a, 0);
        check("reset TX_READY", tx_ready_a, 0);
        check("reset INIT_DONE", init_done_a, 0);

        // Release reset just after an edge; RST must stay low 16 cycles
        push_script(0);
        rstn_a = 1'b1;
        n = 0;
        while (rst_a !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("RST low cycles", n, 16);
        check("LED in RST_HI", led_a, 1);

        // First CS fall 8 cycles after RST rises; poke TX_VALID meanwhile
        n = 0;
        while (cs_a !== 1'b0 && n < 100) begin
            @(posedge clk); #1; n++;
            if (n >= 2 && n < 5) begin
                tx_valid_a = 1'b1;
                tx_data_a  = 8'hAA;
                check("TX_READY before init", tx_ready_a, 0);
            end else begin
                tx_valid_a = 1'b0;
            end
        end
        tx_valid_a = 1'b0;
        check("RST rise to first CS fall", n, 8);

        // Script completes
        n = 0;
        while (init_done_a !== 1'b1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("INIT_DONE reached", init_done_a, 1);
        check("script byte count", nbytes[0], 4);
        check("sleep delay gap >= 40", (fall_at[0][1] - rise_at[0][0]) >= 40, 1);
        check("LED after init", led_a, 1);
        check("TX_READY idle", tx_ready_a, 1);
        check("script queue drained", q_a.size(), 0);

        // Handshake: two back-to-back user bytes with TX_VALID held high
        tx_valid_a = 1'b1; tx_dc_a = 1'b0; tx_data_a = 8'h2C;
        q_a.push_back({1'b0, 8'h2C});
        @(posedge clk); #1;
        acc1 = edges;
        tx_dc_a = 1'b1; tx_data_a = 8'hF8;
        q_a.push_back({1'b1, 8'hF8});
        zeros = 0;
        while (tx_ready_a !== 1'b1 && zeros < 200) begin
            zeros++;
            @(posedge clk); #1;
        end
        check("TX_READY low cycles during user byte", zeros, 36);
        @(posedge clk); #1;
        acc2 = edges;
        tx_valid_a = 1'b0;
        check("acceptance spacing", acc2 - acc1, 37);
        n = 0;
        while (nbytes[0] < 6 && n < 500) begin
            @(posedge clk); #1; n++;
        end
        check("user byte count", nbytes[0], 6);
        check("user queue drained", q_a.size(), 0);

        // Mid-byte reset at the 4th SCK rise of 0x3A
        rstn_a = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        q_a.delete();
        push_script(0);
        rstn_a = 1'b1;
        base = nbytes[0];
        n = 0;
        while (nbytes[0] < base + 1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        r = 0; n = 0; prev = sck_a;
        while (r < 4 && n < 2000) begin
            @(posedge clk); #1; n++;
            if (sck_a && !prev) r++;
            prev = sck_a;
        end
        check("in 0x3A window at abort", cs_a, 0);
        rstn_a = 1'b0;
        @(posedge clk); #1;
        check("abort CS", cs_a, 1);
        check("abort SCK", sck_a, 0);
        check("abort RST", rst_a, 0);
        check("abort INIT_DONE", init_done_a, 0);
        check("abort TX_READY", tx_ready_a, 0);
        q_a.delete();
        repeat (2) begin @(posedge clk); #1; end
        push_script(0);
        rstn_a = 1'b1;
        n = 0;
        while (init_done_a !== 1'b1 && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("replay INIT_DONE", init_done_a, 1);
        check("replay byte count", nbytes[0], base + 1 + 4);
        check("replay queue drained", q_a.size(), 0);

        // Divider sweep on instance B
        push_script(1);
        rstn_b = 1'b1;
        n = 0;
        while (init_done_b !== 1'b1 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check("div5 INIT_DONE", init_done_b, 1);
        check("div5 byte count", nbytes[1], 4);
        check("div5 sleep gap >= 40", (fall_at[1][1] - rise_at[1][0]) >= 40, 1);
        check("div5 queue drained", q_b.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
